// File: rtl/lca_pkg.sv
// Shared LCA pipeline definitions: opcodes, store-data forwarding selects, MEM-stage states.
package lca_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADI = 4'b0001;
   localparam logic [3:0] OP_NDU = 4'b0010;
   localparam logic [3:0] OP_LHI = 4'b0011;
   localparam logic [3:0] OP_LW  = 4'b0100;
   localparam logic [3:0] OP_SW  = 4'b0101;
   localparam logic [3:0] OP_LM  = 4'b0110;
   localparam logic [3:0] OP_SM  = 4'b0111;
   localparam logic [3:0] OP_JAL = 4'b1000;
   localparam logic [3:0] OP_JLR = 4'b1001;
   localparam logic [3:0] OP_BEQ = 4'b1100;

   localparam logic [1:0] F3_REG  = 2'd0;
   localparam logic [1:0] F3_ALU  = 2'd2;
   localparam logic [1:0] F3_LOAD = 2'd3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_t;

   // LM/SM reach MEM already split into LW/SW micro-ops, so only these two touch memory.
   function automatic logic is_mem_op(input logic [5:0] op);
      return (op[5:2] == OP_LW) || (op[5:2] == OP_SW);
   endfunction

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: async reset, load enable, and bubble insert that clears only valid.
module mem_wb_pipe_reg #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_load,
   input  logic          i_bubble,
   input  logic          i_valid,
   input  logic [5:0]    i_op,
   input  logic [2:0]    i_regA,
   input  logic [2:0]    i_regC,
   input  logic [DW-1:0] i_alu_out,
   input  logic [DW-1:0] i_load_data,
   input  logic          i_CCR_write,
   output logic          o_valid,
   output logic [5:0]    o_op,
   output logic [2:0]    o_regA,
   output logic [2:0]    o_regC,
   output logic [DW-1:0] o_alu_out,
   output logic [DW-1:0] o_load_data,
   output logic          o_CCR_write
);

   logic          r_valid;
   logic [5:0]    r_op;
   logic [2:0]    r_regA;
   logic [2:0]    r_regC;
   logic [DW-1:0] r_alu_out;
   logic [DW-1:0] r_load_data;
   logic          r_CCR_write;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid     <= 1'b0;
         r_op        <= '0;
         r_regA      <= '0;
         r_regC      <= '0;
         r_alu_out   <= '0;
         r_load_data <= '0;
         r_CCR_write <= 1'b0;
      end else if (i_load) begin
         r_valid     <= i_valid;
         r_op        <= i_op;
         r_regA      <= i_regA;
         r_regC      <= i_regC;
         r_alu_out   <= i_alu_out;
         r_load_data <= i_load_data;
         r_CCR_write <= i_CCR_write;
      end else if (i_bubble) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid     = r_valid;
   assign o_op        = r_op;
   assign o_regA      = r_regA;
   assign o_regC      = r_regC;
   assign o_alu_out   = r_alu_out;
   assign o_load_data = r_load_data;
   assign o_CCR_write = r_CCR_write;

endmodule

// File: rtl/mem_access_stage.sv
// LCA MEM stage: store-data forwarding mux, req/ready data-memory handshake, MEM/WB register.
// Optional access abort after TIMEOUT_CYCLES is enabled with `define MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage #(
   parameter int DW             = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ex_mem_valid,
   input  logic [5:0]    ex_mem_op,
   input  logic [2:0]    ex_mem_regA,
   input  logic [2:0]    ex_mem_regC,
   input  logic [DW-1:0] ex_mem_alu_out,
   input  logic [DW-1:0] ex_mem_regA_data,
   input  logic          ex_mem_CCR_write,
   input  logic [1:0]    F3,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [DW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic [DW-1:0] dmem_rdata,
   input  logic          dmem_ready,
   output logic          mem_stall,
   output logic          mem_timeout,
   output logic          mem_wb_valid,
   output logic [5:0]    mem_wb_op,
   output logic [2:0]    mem_wb_regA,
   output logic [2:0]    mem_wb_regC,
   output logic [DW-1:0] mem_wb_alu_out,
   output logic [DW-1:0] mem_wb_load_data,
   output logic          mem_wb_CCR_write,
   output logic          dbg_state
);

   import lca_pkg::*;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit the 8-bit wait counter (1..255)");
   end

   mem_state_t    r_state;
   mem_state_t    w_next_state;
   logic          r_req;
   logic          r_we;
   logic [DW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic          r_timeout;
   logic          w_is_mem;
   logic          w_accept;
   logic          w_retire;
   logic          w_bubble;
   logic          w_timeout;
   logic [DW-1:0] w_store_data;
   logic [DW-1:0] w_load_data;
   logic          w_is_lw;

   assign w_is_mem = ex_mem_valid && is_mem_op(ex_mem_op);
   assign w_is_lw  = (ex_mem_op[5:2] == OP_LW);

   // Encoding 1 is unused by the forwarding unit and falls back to the ID-stage value.
   always_comb begin
      w_store_data = ex_mem_regA_data;
      case (F3)
         F3_ALU:  w_store_data = mem_wb_alu_out;
         F3_LOAD: w_store_data = mem_wb_load_data;
         default: w_store_data = ex_mem_regA_data;
      endcase
   end

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic [7:0] r_wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
         r_wait_cnt <= '0;
      end else begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // Fires in the TIMEOUT_CYCLES-th ACCESS cycle; a ready in the same cycle takes priority.
   assign w_timeout = (r_state == ST_ACCESS) && !dmem_ready &&
                      (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_retire     = 1'b0;
      w_bubble     = 1'b0;
      mem_stall    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_is_mem) begin
               w_accept     = 1'b1;
               w_bubble     = 1'b1;
               mem_stall    = 1'b1;
               w_next_state = ST_ACCESS;
            end else begin
               w_retire = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (dmem_ready || w_timeout) begin
               w_retire     = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_bubble  = 1'b1;
               mem_stall = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_load_data = '0;
      if (r_state == ST_ACCESS) begin
         if (dmem_ready) begin
            w_load_data = w_is_lw ? dmem_rdata : '0;
         end else if (w_timeout) begin
            w_load_data = '1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_timeout <= w_timeout;
         if (w_accept) begin
            r_req   <= 1'b1;
            r_we    <= (ex_mem_op[5:2] == OP_SW);
            r_addr  <= ex_mem_alu_out;
            r_wdata <= w_store_data;
         end else if (w_retire) begin
            r_req <= 1'b0;
         end
      end
   end

   mem_wb_pipe_reg #(.DW(DW)) u_mem_wb (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_retire),
      .i_bubble    (w_bubble),
      .i_valid     (ex_mem_valid),
      .i_op        (ex_mem_op),
      .i_regA      (ex_mem_regA),
      .i_regC      (ex_mem_regC),
      .i_alu_out   (ex_mem_alu_out),
      .i_load_data (w_load_data),
      .i_CCR_write (ex_mem_CCR_write),
      .o_valid     (mem_wb_valid),
      .o_op        (mem_wb_op),
      .o_regA      (mem_wb_regA),
      .o_regC      (mem_wb_regC),
      .o_alu_out   (mem_wb_alu_out),
      .o_load_data (mem_wb_load_data),
      .o_CCR_write (mem_wb_CCR_write)
   );

   assign dmem_req    = r_req;
   assign dmem_we     = r_we;
   assign dmem_addr   = r_addr;
   assign dmem_wdata  = r_wdata;
   assign mem_timeout = r_timeout;
   assign dbg_state   = r_state;

endmodule
